fpu_mul_core: RTL

Sequential IEEE-754 single-precision multiplier, the multiply stage of the FPU. The arithmetic FSM starts it from `arith_mul_st` and waits in `arith_mul_done_st` for its result. It works as follows:
- unpacks both operands and handles zero, Inf and NaN cases up front;
- multiplies the 24-bit significands by iterative shift-add, one bit per two cycles, walking the shared `e_mul_states` sequence;
- normalises, truncates and packs the result, then holds it until acknowledged.

---
 rtl/pa_fpu.sv | 22 ++
 rtl/fpu_mul_core.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pa_fpu.sv
// pa_fpu: shared FPU definitions.
//   e_mul_states  - state sequence of the multiply core, also walked by the
//                   arithmetic FSM while it waits on the multiplier.
//   FPU_MANT_W    - single-precision significand width including hidden bit.
//   FPU_EXP_BIAS  - single-precision exponent bias.
//   FPU_QNAN      - canonical quiet NaN returned for invalid operations.
package pa_fpu;

  localparam int          FPU_MANT_W   = 24;
  localparam int          FPU_EXP_BIAS = 127;
  localparam logic [31:0] FPU_QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    mul_idle_st          = 3'd0,
    mul_start_st         = 3'd1,
    mul_product_add_st   = 3'd2,
    mul_product_shift_st = 3'd3,
    mul_result_set_st    = 3'd4,
    mul_result_valid_st  = 3'd5
  } e_mul_states;

endpackage

// File: rtl/fpu_mul_core.sv
// fpu_mul_core: sequential IEEE-754 single-precision multiplier.
// Significands are multiplied by shift-add, one multiplier bit every two
// cycles; the product is normalised, truncated and held until acknowledged.
// Ports:
//   clk        rising-edge clock
//   arst       asynchronous active-high reset
//   start      request, sampled only while idle
//   a_operand  IEEE single, latched on the accepted start
//   b_operand  IEEE single, latched on the accepted start
//   ack        result consumed, honoured only while done=1
//   busy       high in every state except idle
//   done       high while the result is valid
//   result     product, stable while done=1
module fpu_mul_core
  import pa_fpu::*;
#(
  parameter int MANT_W = FPU_MANT_W
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int                PROD_W   = 2 * MANT_W;
  localparam int                CNT_W    = $clog2(MANT_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MANT_W - 1);

  e_mul_states         r_state;
  e_mul_states         w_state_nxt;

  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic [MANT_W-1:0]   r_ma;
  logic [MANT_W-1:0]   r_mb;
  logic [PROD_W-1:0]   r_prod;
  logic                r_carry;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_special;
  logic [31:0]         r_special_val;
  logic [31:0]         r_result;

  // Exponent overflow/underflow saturation and final packing.
  function automatic logic [31:0] sat_pack(input logic s,
                                           input logic signed [9:0] e,
                                           input logic [22:0] f);
    if (e >= 10'sd255)   return {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0) return {s, 31'd0};
    else                  return {s, e[7:0], f};
  endfunction

  // Operand classification on the latched operands
  logic w_sign;
  logic w_a_nan, w_a_inf, w_a_zero;
  logic w_b_nan, w_b_inf, w_b_zero;
  logic w_is_special;
  logic [31:0] w_special_val;

  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_a_nan  = (&r_a[30:23]) &&  (|r_a[22:0]);
  assign w_a_inf  = (&r_a[30:23]) && !(|r_a[22:0]);
  assign w_a_zero = (r_a[30:23] == 8'd0);  // denormals flush to zero
  assign w_b_nan  = (&r_b[30:23]) &&  (|r_b[22:0]);
  assign w_b_inf  = (&r_b[30:23]) && !(|r_b[22:0]);
  assign w_b_zero = (r_b[30:23] == 8'd0);
  assign w_is_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

  always_comb begin
    w_special_val = {w_sign, 31'd0};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_special_val = FPU_QNAN;
    else if (w_a_inf || w_b_inf)
      w_special_val = {w_sign, 8'hFF, 23'd0};
  end

  // Normalisation of the finished product
  logic               w_top;
  logic [22:0]        w_frac;
  logic signed [9:0]  w_exp;
  logic [31:0]        w_norm;
  logic               w_unused;

  assign w_top  = r_prod[PROD_W-1];
  assign w_frac = w_top ? r_prod[PROD_W-2 -: 23] : r_prod[PROD_W-3 -: 23];
  assign w_exp  = $signed({2'b00, r_a[30:23]}) + $signed({2'b00, r_b[30:23]})
                - $signed(10'(FPU_EXP_BIAS)) + $signed({9'd0, w_top});
  assign w_norm = sat_pack(w_sign, w_exp, w_frac);
  // The product LSB only ever shifts out; truncation never looks at it.
  assign w_unused = r_prod[0];

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= mul_idle_st;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      mul_idle_st:          if (start) w_state_nxt = mul_start_st;
      mul_start_st:         w_state_nxt = w_is_special ? mul_result_set_st : mul_product_add_st;
      mul_product_add_st:   w_state_nxt = mul_product_shift_st;
      mul_product_shift_st: w_state_nxt = (r_cnt == CNT_LAST) ? mul_result_set_st
                                                              : mul_product_add_st;
      mul_result_set_st:    w_state_nxt = mul_result_valid_st;
      mul_result_valid_st:  if (ack) w_state_nxt = mul_idle_st;
      default:              w_state_nxt = mul_idle_st;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (r_state != mul_idle_st);
    done = (r_state == mul_result_valid_st);
  end
  assign result = r_result;

  // Datapath: operand latch, shift-add iteration
  always_ff @(posedge clk) begin
    case (r_state)
      mul_idle_st: if (start) begin
        r_a     <= a_operand;
        r_b     <= b_operand;
        r_ma    <= (a_operand[30:23] != 8'd0) ? MANT_W'({1'b1, a_operand[22:0]}) : '0;
        r_mb    <= (b_operand[30:23] != 8'd0) ? MANT_W'({1'b1, b_operand[22:0]}) : '0;
        r_prod  <= '0;
        r_carry <= 1'b0;
        r_cnt   <= '0;
      end
      mul_start_st: begin
        r_special     <= w_is_special;
        r_special_val <= w_special_val;
      end
      mul_product_add_st: if (r_mb[0]) begin
        {r_carry, r_prod[PROD_W-1 -: MANT_W]} <= {1'b0, r_prod[PROD_W-1 -: MANT_W]}
                                               + {1'b0, r_ma};
      end
      mul_product_shift_st: begin
        r_prod  <= {r_carry, r_prod[PROD_W-1:1]};
        r_carry <= 1'b0;
        r_mb    <= r_mb >> 1;
        r_cnt   <= r_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  // Result register
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      r_result <= '0;
    else if (r_state == mul_result_set_st)
      r_result <= r_special ? r_special_val : w_norm;
  end

endmodule
